// File: rtl/tlb_mmu_if.sv
// Bus between CP0/pipeline and the joint TLB: two translation ports,
// the tlbwi write port, the tlbr read port and the tlbp probe port.
interface tlb_mmu_if #(parameter int IW = 4);
   // fetch translation port
   logic          s0_req;
   logic [18:0]   s0_vpn2;
   logic          s0_odd;
   logic [7:0]    s0_asid;
   logic          s0_rvalid;
   logic          s0_found;
   logic [IW-1:0] s0_index;
   logic [19:0]   s0_pfn;
   logic [2:0]    s0_c;
   logic          s0_d;
   logic          s0_v;
   // data translation port
   logic          s1_req;
   logic [18:0]   s1_vpn2;
   logic          s1_odd;
   logic [7:0]    s1_asid;
   logic          s1_rvalid;
   logic          s1_found;
   logic [IW-1:0] s1_index;
   logic [19:0]   s1_pfn;
   logic [2:0]    s1_c;
   logic          s1_d;
   logic          s1_v;
   // tlbwi write port
   logic          we;
   logic [IW-1:0] w_index;
   logic [18:0]   w_vpn2;
   logic [7:0]    w_asid;
   logic          w_g0, w_g1;
   logic [19:0]   w_pfn0, w_pfn1;
   logic [2:0]    w_c0, w_c1;
   logic          w_d0, w_d1, w_v0, w_v1;
   // tlbr read port
   logic [IW-1:0] r_index;
   logic [18:0]   r_vpn2;
   logic [7:0]    r_asid;
   logic          r_g0, r_g1;
   logic [19:0]   r_pfn0, r_pfn1;
   logic [2:0]    r_c0, r_c1;
   logic          r_d0, r_d1, r_v0, r_v1;
   // tlbp probe port
   logic          p_req;
   logic [18:0]   p_vpn2;
   logic [7:0]    p_asid;
   logic          p_done;
   logic          p_found;
   logic [IW-1:0] p_index;

   modport master (
      output s0_req, s0_vpn2, s0_odd, s0_asid,
      input  s0_rvalid, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
      output s1_req, s1_vpn2, s1_odd, s1_asid,
      input  s1_rvalid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
      output we, w_index, w_vpn2, w_asid, w_g0, w_g1,
      output w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
      output r_index,
      input  r_vpn2, r_asid, r_g0, r_g1, r_pfn0, r_c0, r_d0, r_v0,
      input  r_pfn1, r_c1, r_d1, r_v1,
      output p_req, p_vpn2, p_asid,
      input  p_done, p_found, p_index
   );

   modport slave (
      input  s0_req, s0_vpn2, s0_odd, s0_asid,
      output s0_rvalid, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
      input  s1_req, s1_vpn2, s1_odd, s1_asid,
      output s1_rvalid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
      input  we, w_index, w_vpn2, w_asid, w_g0, w_g1,
      input  w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
      input  r_index,
      output r_vpn2, r_asid, r_g0, r_g1, r_pfn0, r_c0, r_d0, r_v0,
      output r_pfn1, r_c1, r_d1, r_v1,
      input  p_req, p_vpn2, p_asid,
      output p_done, p_found, p_index
   );
endinterface

// File: rtl/tlb_mmu.sv
// Fully associative MIPS-style joint TLB. Each entry maps an even/odd
// pair of 4 KB pages. Two registered translation ports, a registered
// probe and a combinational read of the stored entries.
module tlb_mmu #(
   parameter int TLBNUM = 16
) (
   input  logic       clk,
   input  logic       resetn,
   tlb_mmu_if.slave   bus
);
   localparam int IW = $clog2(TLBNUM);

   logic [TLBNUM-1:0] r_ent_e;
   logic [18:0]       r_ent_vpn2 [TLBNUM];
   logic [7:0]        r_ent_asid [TLBNUM];
   logic              r_ent_g    [TLBNUM];
   logic [19:0]       r_ent_pfn0 [TLBNUM];
   logic [19:0]       r_ent_pfn1 [TLBNUM];
   logic [2:0]        r_ent_c0   [TLBNUM];
   logic [2:0]        r_ent_c1   [TLBNUM];
   logic              r_ent_d0   [TLBNUM];
   logic              r_ent_d1   [TLBNUM];
   logic              r_ent_v0   [TLBNUM];
   logic              r_ent_v1   [TLBNUM];

   logic [TLBNUM-1:0] w_m0, w_m1, w_mp;
   logic [IW:0]       w_h0, w_h1, w_hp;
   logic [24:0]       w_pg0, w_pg1;

   // Lowest matching index wins; result is {found, index}, zero on miss.
   function automatic logic [IW:0] f_prio(input logic [TLBNUM-1:0] m);
      f_prio = '0;
      for (int i = TLBNUM - 1; i >= 0; i--)
         if (m[i]) f_prio = {1'b1, i[IW-1:0]};
   endfunction

   // Selected page record {pfn, c, d, v}; zero on miss.
   function automatic logic [24:0] f_page(input logic [IW:0] h, input logic odd);
      logic [IW-1:0] k;
      k = h[IW-1:0];
      f_page = '0;
      if (h[IW])
         f_page = odd ? {r_ent_pfn1[k], r_ent_c1[k], r_ent_d1[k], r_ent_v1[k]}
                      : {r_ent_pfn0[k], r_ent_c0[k], r_ent_d0[k], r_ent_v0[k]};
   endfunction

   // Entry storage: tlbwi writes one entry and marks it existing.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ent_e <= '0;
         for (int i = 0; i < TLBNUM; i++) begin
            r_ent_vpn2[i] <= '0;
            r_ent_asid[i] <= '0;
            r_ent_g[i]    <= 1'b0;
            r_ent_pfn0[i] <= '0;
            r_ent_pfn1[i] <= '0;
            r_ent_c0[i]   <= '0;
            r_ent_c1[i]   <= '0;
            r_ent_d0[i]   <= 1'b0;
            r_ent_d1[i]   <= 1'b0;
            r_ent_v0[i]   <= 1'b0;
            r_ent_v1[i]   <= 1'b0;
         end
      end else if (bus.we) begin
         r_ent_e[bus.w_index]    <= 1'b1;
         r_ent_vpn2[bus.w_index] <= bus.w_vpn2;
         r_ent_asid[bus.w_index] <= bus.w_asid;
         r_ent_g[bus.w_index]    <= bus.w_g0 & bus.w_g1;
         r_ent_pfn0[bus.w_index] <= bus.w_pfn0;
         r_ent_pfn1[bus.w_index] <= bus.w_pfn1;
         r_ent_c0[bus.w_index]   <= bus.w_c0;
         r_ent_c1[bus.w_index]   <= bus.w_c1;
         r_ent_d0[bus.w_index]   <= bus.w_d0;
         r_ent_d1[bus.w_index]   <= bus.w_d1;
         r_ent_v0[bus.w_index]   <= bus.w_v0;
         r_ent_v1[bus.w_index]   <= bus.w_v1;
      end
   end

   // Per-entry match vectors; V is deliberately not part of the match.
   always_comb begin
      w_m0 = '0;
      w_m1 = '0;
      w_mp = '0;
      for (int i = 0; i < TLBNUM; i++) begin
         w_m0[i] = r_ent_e[i] & (r_ent_vpn2[i] == bus.s0_vpn2) &
                   (r_ent_g[i] | (r_ent_asid[i] == bus.s0_asid));
         w_m1[i] = r_ent_e[i] & (r_ent_vpn2[i] == bus.s1_vpn2) &
                   (r_ent_g[i] | (r_ent_asid[i] == bus.s1_asid));
         w_mp[i] = r_ent_e[i] & (r_ent_vpn2[i] == bus.p_vpn2) &
                   (r_ent_g[i] | (r_ent_asid[i] == bus.p_asid));
      end
   end

   assign w_h0  = f_prio(w_m0);
   assign w_h1  = f_prio(w_m1);
   assign w_hp  = f_prio(w_mp);
   assign w_pg0 = f_page(w_h0, bus.s0_odd);
   assign w_pg1 = f_page(w_h1, bus.s1_odd);

   // Lookup/probe results: captured on request, held until the next one.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.s0_rvalid <= 1'b0;
         bus.s0_found  <= 1'b0;
         bus.s0_index  <= '0;
         {bus.s0_pfn, bus.s0_c, bus.s0_d, bus.s0_v} <= '0;
         bus.s1_rvalid <= 1'b0;
         bus.s1_found  <= 1'b0;
         bus.s1_index  <= '0;
         {bus.s1_pfn, bus.s1_c, bus.s1_d, bus.s1_v} <= '0;
         bus.p_done    <= 1'b0;
         bus.p_found   <= 1'b0;
         bus.p_index   <= '0;
      end else begin
         bus.s0_rvalid <= bus.s0_req;
         bus.s1_rvalid <= bus.s1_req;
         bus.p_done    <= bus.p_req;
         if (bus.s0_req) begin
            bus.s0_found <= w_h0[IW];
            bus.s0_index <= w_h0[IW-1:0];
            {bus.s0_pfn, bus.s0_c, bus.s0_d, bus.s0_v} <= w_pg0;
         end
         if (bus.s1_req) begin
            bus.s1_found <= w_h1[IW];
            bus.s1_index <= w_h1[IW-1:0];
            {bus.s1_pfn, bus.s1_c, bus.s1_d, bus.s1_v} <= w_pg1;
         end
         if (bus.p_req) begin
            bus.p_found <= w_hp[IW];
            bus.p_index <= w_hp[IW-1:0];
         end
      end
   end

   // tlbr read port straight from the stored array.
   assign bus.r_vpn2 = r_ent_vpn2[bus.r_index];
   assign bus.r_asid = r_ent_asid[bus.r_index];
   assign bus.r_g0   = r_ent_g[bus.r_index];
   assign bus.r_g1   = r_ent_g[bus.r_index];
   assign bus.r_pfn0 = r_ent_pfn0[bus.r_index];
   assign bus.r_c0   = r_ent_c0[bus.r_index];
   assign bus.r_d0   = r_ent_d0[bus.r_index];
   assign bus.r_v0   = r_ent_v0[bus.r_index];
   assign bus.r_pfn1 = r_ent_pfn1[bus.r_index];
   assign bus.r_c1   = r_ent_c1[bus.r_index];
   assign bus.r_d1   = r_ent_d1[bus.r_index];
   assign bus.r_v1   = r_ent_v1[bus.r_index];
endmodule
